// File: rtl/hcr_cmd_ctrl.sv
// HCR command controller: turns a rising pio_hcr_go into one command on the
// engine request channel, waits for the engine's completion (or times out),
// optionally posts a completion event, then pulses pio_hcr_clear to drop go.
module hcr_cmd_ctrl #(
  parameter logic [31:0] TIMEOUT_CYC    = 32'd1048576,
  parameter logic [7:0]  TIMEOUT_STATUS = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  // HCR register space
  input  logic [63:0] pio_hcr_in_param,
  input  logic [31:0] pio_hcr_in_modifier,
  input  logic [63:0] pio_hcr_out_dma_addr,
  input  logic [15:0] pio_hcr_token,
  input  logic [7:0]  pio_hcr_op_modifier,
  input  logic [11:0] pio_hcr_op,
  input  logic        pio_hcr_go,
  input  logic        pio_hcr_event,
  output logic [63:0] pio_hcr_out_param,
  output logic [7:0]  pio_hcr_status,
  output logic        pio_hcr_clear,
  // command issue channel
  output logic        cmd_req_valid,
  input  logic        cmd_req_ready,
  output logic [11:0] cmd_req_op,
  output logic [7:0]  cmd_req_op_mod,
  output logic [63:0] cmd_req_in_param,
  output logic [31:0] cmd_req_in_mod,
  output logic [63:0] cmd_req_out_addr,
  // engine completion channel
  input  logic        cmd_rsp_valid,
  input  logic [7:0]  cmd_rsp_status,
  input  logic [63:0] cmd_rsp_out_param,
  output logic        cmd_rsp_ready,
  // completion-event channel
  output logic        eq_evt_valid,
  input  logic        eq_evt_ready,
  output logic [15:0] eq_evt_token,
  output logic [7:0]  eq_evt_status,
  output logic        hcr_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVENT, CLEAR} state_t;

  state_t      state, state_nxt;
  logic        go_d;
  // go_armed is set only once go has been seen low after reset, so a go that
  // was already high when reset released cannot look like a fresh rise.
  logic        go_armed;
  logic [31:0] tmo_cnt;

  logic [11:0] op_q;
  logic [7:0]  op_mod_q;
  logic [63:0] in_param_q;
  logic [31:0] in_mod_q;
  logic [63:0] out_addr_q;
  logic [15:0] token_q;
  logic        event_q;

  logic start, req_hs, rsp_hs, tmo_hit, abort, in_flight;

  assign in_flight = (state == ISSUE) || (state == WAIT);
  assign start     = pio_hcr_go && !go_d && go_armed && (state == IDLE);
  assign req_hs    = (state == ISSUE) && cmd_req_ready;
  assign rsp_hs    = (state == WAIT) && cmd_rsp_valid;
  assign tmo_hit   = in_flight && (tmo_cnt == TIMEOUT_CYC - 32'd1);
  // A handshake landing on the timeout cycle takes priority over the abort.
  assign abort     = tmo_hit && !req_hs && !rsp_hs;

  assign cmd_req_op       = op_q;
  assign cmd_req_op_mod   = op_mod_q;
  assign cmd_req_in_param = in_param_q;
  assign cmd_req_in_mod   = in_mod_q;
  assign cmd_req_out_addr = out_addr_q;
  assign eq_evt_token     = token_q;
  assign eq_evt_status    = pio_hcr_status;

  // State register, go edge detector and issue-to-response timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      go_d     <= 1'b0;
      go_armed <= 1'b0;
      tmo_cnt  <= 32'd0;
    end else begin
      state <= state_nxt;
      go_d  <= pio_hcr_go;
      if (!pio_hcr_go) go_armed <= 1'b1;
      if (start) tmo_cnt <= 32'd0;
      else if (in_flight) tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Command fields captured at start, results captured on completion/timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q              <= '0;
      op_mod_q          <= '0;
      in_param_q        <= '0;
      in_mod_q          <= '0;
      out_addr_q        <= '0;
      token_q           <= '0;
      event_q           <= 1'b0;
      pio_hcr_status    <= '0;
      pio_hcr_out_param <= '0;
    end else begin
      if (start) begin
        op_q       <= pio_hcr_op;
        op_mod_q   <= pio_hcr_op_modifier;
        in_param_q <= pio_hcr_in_param;
        in_mod_q   <= pio_hcr_in_modifier;
        out_addr_q <= pio_hcr_out_dma_addr;
        token_q    <= pio_hcr_token;
        event_q    <= pio_hcr_event;
      end
      if (rsp_hs) begin
        pio_hcr_status    <= cmd_rsp_status;
        pio_hcr_out_param <= cmd_rsp_out_param;
      end else if (abort) begin
        pio_hcr_status    <= TIMEOUT_STATUS;
        pio_hcr_out_param <= '0;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    cmd_req_valid = 1'b0;
    cmd_rsp_ready = 1'b0;
    eq_evt_valid  = 1'b0;
    pio_hcr_clear = 1'b0;
    hcr_busy      = 1'b1;
    case (state)
      IDLE: begin
        hcr_busy      = 1'b0;
        // Always accept in IDLE so a response arriving after a timeout drains.
        cmd_rsp_ready = !rst;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        cmd_req_valid = 1'b1;
        if (req_hs) state_nxt = WAIT;
        else if (abort) state_nxt = event_q ? EVENT : CLEAR;
      end
      WAIT: begin
        cmd_rsp_ready = !rst;
        if (rsp_hs || abort) state_nxt = event_q ? EVENT : CLEAR;
      end
      EVENT: begin
        eq_evt_valid = 1'b1;
        if (eq_evt_ready) state_nxt = CLEAR;
      end
      CLEAR: begin
        pio_hcr_clear = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hcr_cmd_ctrl.sv
// Bench for hcr_cmd_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all continuously compared against a transaction model.
module tb_hcr_cmd_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pio_hcr_in_param = '0;
  logic [31:0] pio_hcr_in_modifier = '0;
  logic [63:0] pio_hcr_out_dma_addr = '0;
  logic [15:0] pio_hcr_token = '0;
  logic [7:0]  pio_hcr_op_modifier = '0;
  logic [11:0] pio_hcr_op = '0;
  logic        pio_hcr_go = 1'b0;
  logic        pio_hcr_event = 1'b0;
  logic [63:0] pio_hcr_out_param;
  logic [7:0]  pio_hcr_status;
  logic        pio_hcr_clear;
  logic        cmd_req_valid;
  logic        cmd_req_ready = 1'b0;
  logic [11:0] cmd_req_op;
  logic [7:0]  cmd_req_op_mod;
  logic [63:0] cmd_req_in_param;
  logic [31:0] cmd_req_in_mod;
  logic [63:0] cmd_req_out_addr;
  logic        cmd_rsp_valid = 1'b0;
  logic [7:0]  cmd_rsp_status = '0;
  logic [63:0] cmd_rsp_out_param = '0;
  logic        cmd_rsp_ready;
  logic        eq_evt_valid;
  logic        eq_evt_ready = 1'b0;
  logic [15:0] eq_evt_token;
  logic [7:0]  eq_evt_status;
  logic        hcr_busy;

  hcr_cmd_ctrl #(.TIMEOUT_CYC(32'd16), .TIMEOUT_STATUS(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .pio_hcr_in_param(pio_hcr_in_param), .pio_hcr_in_modifier(pio_hcr_in_modifier),
    .pio_hcr_out_dma_addr(pio_hcr_out_dma_addr), .pio_hcr_token(pio_hcr_token),
    .pio_hcr_op_modifier(pio_hcr_op_modifier), .pio_hcr_op(pio_hcr_op),
    .pio_hcr_go(pio_hcr_go), .pio_hcr_event(pio_hcr_event),
    .pio_hcr_out_param(pio_hcr_out_param), .pio_hcr_status(pio_hcr_status),
    .pio_hcr_clear(pio_hcr_clear),
    .cmd_req_valid(cmd_req_valid), .cmd_req_ready(cmd_req_ready),
    .cmd_req_op(cmd_req_op), .cmd_req_op_mod(cmd_req_op_mod),
    .cmd_req_in_param(cmd_req_in_param), .cmd_req_in_mod(cmd_req_in_mod),
    .cmd_req_out_addr(cmd_req_out_addr),
    .cmd_rsp_valid(cmd_rsp_valid), .cmd_rsp_status(cmd_rsp_status),
    .cmd_rsp_out_param(cmd_rsp_out_param), .cmd_rsp_ready(cmd_rsp_ready),
    .eq_evt_valid(eq_evt_valid), .eq_evt_ready(eq_evt_ready),
    .eq_evt_token(eq_evt_token), .eq_evt_status(eq_evt_status),
    .hcr_busy(hcr_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // One command at a time moves through: waiting to be issued, waiting for
  // the engine, waiting for the event to be taken, and the clear pulse.
  bit          m_req, m_rsp, m_evt, m_clr;
  int          m_age;
  bit          m_go_prev, m_armed;
  logic [7:0]  m_status;
  logic [63:0] m_out;
  logic [11:0] m_op;
  logic [7:0]  m_opm;
  logic [63:0] m_inp;
  logic [31:0] m_inm;
  logic [63:0] m_addr;
  logic [15:0] m_tok;
  bit          m_ev;

  function automatic bit m_busy();
    return m_req | m_rsp | m_evt | m_clr;
  endfunction

  task automatic m_finish();
    m_req = 0;
    m_rsp = 0;
    if (m_ev) m_evt = 1;
    else m_clr = 1;
  endtask

  task automatic m_timeout();
    m_status = 8'hFF;
    m_out    = '0;
    m_finish();
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        {m_req, m_rsp, m_evt, m_clr} = '0;
        m_age = 0; m_go_prev = 0; m_armed = 0;
        m_status = '0; m_out = '0;
        m_op = '0; m_opm = '0; m_inp = '0; m_inm = '0; m_addr = '0; m_tok = '0; m_ev = 0;
      end else begin
        if (!m_busy()) begin
          if (pio_hcr_go && !m_go_prev && m_armed) begin
            m_op = pio_hcr_op; m_opm = pio_hcr_op_modifier; m_inp = pio_hcr_in_param;
            m_inm = pio_hcr_in_modifier; m_addr = pio_hcr_out_dma_addr;
            m_tok = pio_hcr_token; m_ev = pio_hcr_event;
            m_req = 1; m_age = 0;
          end
        end else if (m_req) begin
          if (cmd_req_ready) begin m_req = 0; m_rsp = 1; m_age++; end
          else if (m_age == TO - 1) m_timeout();
          else m_age++;
        end else if (m_rsp) begin
          if (cmd_rsp_valid) begin
            m_status = cmd_rsp_status; m_out = cmd_rsp_out_param; m_finish();
          end else if (m_age == TO - 1) m_timeout();
          else m_age++;
        end else if (m_evt) begin
          if (eq_evt_ready) begin m_evt = 0; m_clr = 1; end
        end else begin
          m_clr = 0;
        end
        m_go_prev = pio_hcr_go;
        if (!pio_hcr_go) m_armed = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 64'(hcr_busy), 64'(m_busy()));
      chk("req_valid", 64'(cmd_req_valid), 64'(m_req));
      chk("rsp_ready", 64'(cmd_rsp_ready), 64'(!rst && (m_rsp || !m_busy())));
      chk("evt_valid", 64'(eq_evt_valid), 64'(m_evt));
      chk("clear", 64'(pio_hcr_clear), 64'(m_clr));
      chk("status", 64'(pio_hcr_status), 64'(m_status));
      chk("out_param", pio_hcr_out_param, m_out);
      if (m_req) begin
        chk("req_op", 64'(cmd_req_op), 64'(m_op));
        chk("req_op_mod", 64'(cmd_req_op_mod), 64'(m_opm));
        chk("req_in_param", cmd_req_in_param, m_inp);
        chk("req_in_mod", 64'(cmd_req_in_mod), 64'(m_inm));
        chk("req_out_addr", cmd_req_out_addr, m_addr);
      end
      if (m_evt) begin
        chk("evt_token", 64'(eq_evt_token), 64'(m_tok));
        chk("evt_status", 64'(eq_evt_status), 64'(m_status));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input logic [11:0] op, input logic [7:0] opm, input logic [63:0] inp,
                         input logic [31:0] inm, input logic [63:0] addr,
                         input logic [15:0] tok, input logic ev);
    pio_hcr_op = op; pio_hcr_op_modifier = opm; pio_hcr_in_param = inp;
    pio_hcr_in_modifier = inm; pio_hcr_out_dma_addr = addr;
    pio_hcr_token = tok; pio_hcr_event = ev;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("rst_busy", 64'(hcr_busy), 64'(0));
    chk("rst_rsp_ready", 64'(cmd_rsp_ready), 64'(0));
    chk("rst_status", 64'(pio_hcr_status), 64'(0));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rel_rsp_ready", 64'(cmd_rsp_ready), 64'(1));
    tick();

    // Basic command without event
    set_cmd(12'h00A, 8'h00, 64'h1234, 32'h0, 64'h0, 16'h0, 1'b0);
    cmd_req_ready = 1; pio_hcr_go = 1; tick();
    chk("t1_req_valid", 64'(cmd_req_valid), 64'(1));
    chk("t1_op", 64'(cmd_req_op), 64'(12'h00A));
    chk("t1_in_param", cmd_req_in_param, 64'h1234);
    tick();
    chk("t1_req_once", 64'(cmd_req_valid), 64'(0));
    repeat (4) tick();
    chk("t1_no_clear_yet", 64'(pio_hcr_clear), 64'(0));
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h00; cmd_rsp_out_param = 64'hBEEF; tick();
    cmd_rsp_valid = 0;
    chk("t1_clear", 64'(pio_hcr_clear), 64'(1));
    chk("t1_out", pio_hcr_out_param, 64'hBEEF);
    chk("t1_status", 64'(pio_hcr_status), 64'(8'h00));
    chk("t1_model_out", m_out, 64'hBEEF);
    tick();
    chk("t1_clear_once", 64'(pio_hcr_clear), 64'(0));
    chk("t1_idle", 64'(hcr_busy), 64'(0));

    // Command with event, event consumer stalls 3 cycles
    pio_hcr_go = 0; tick();
    set_cmd(12'h00A, 8'h00, 64'h1234, 32'h0, 64'h0, 16'h55AA, 1'b1);
    eq_evt_ready = 0; pio_hcr_go = 1; tick();
    tick();
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h00; cmd_rsp_out_param = 64'hBEEF; tick();
    cmd_rsp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_evt_valid", 64'(eq_evt_valid), 64'(1));
      chk("t2_token", 64'(eq_evt_token), 64'(16'h55AA));
      chk("t2_no_clear", 64'(pio_hcr_clear), 64'(0));
      if (i == 3) eq_evt_ready = 1;
      tick();
    end
    eq_evt_ready = 0;
    chk("t2_evt_done", 64'(eq_evt_valid), 64'(0));
    chk("t2_clear", 64'(pio_hcr_clear), 64'(1));
    tick();
    chk("t2_clear_once", 64'(pio_hcr_clear), 64'(0));

    // Engine never responds: timeout, then a late response is drained
    pio_hcr_go = 0; tick();
    set_cmd(12'h011, 8'h01, 64'h1, 32'h2, 64'h3, 16'h4, 1'b0);
    pio_hcr_go = 1; tick();
    chk("t3_issue", 64'(cmd_req_valid), 64'(1));
    repeat (15) tick();
    chk("t3_pre_status", 64'(pio_hcr_status), 64'(8'h00));
    chk("t3_pre_clear", 64'(pio_hcr_clear), 64'(0));
    tick();
    chk("t3_tmo_status", 64'(pio_hcr_status), 64'(8'hFF));
    chk("t3_tmo_out", pio_hcr_out_param, 64'h0);
    chk("t3_tmo_clear", 64'(pio_hcr_clear), 64'(1));
    chk("t3_model_status", 64'(m_status), 64'(8'hFF));
    tick();
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h33; cmd_rsp_out_param = 64'h77;
    chk("t3_drain_ready", 64'(cmd_rsp_ready), 64'(1));
    tick();
    cmd_rsp_valid = 0;
    chk("t3_late_status", 64'(pio_hcr_status), 64'(8'hFF));
    chk("t3_late_out", pio_hcr_out_param, 64'h0);
    chk("t3_late_idle", 64'(hcr_busy), 64'(0));

    // Request stalled 10 cycles; fields stable, second go rise ignored
    pio_hcr_go = 0; tick();
    set_cmd(12'h3C5, 8'h7E, 64'hA5A5_0000_1111_2222, 32'hDEAD_BEEF,
            64'h0000_0001_0000_0040, 16'h1234, 1'b0);
    cmd_req_ready = 0; pio_hcr_go = 1; tick();
    set_cmd(12'h000, 8'h00, 64'h0, 32'h0, 64'h0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid", 64'(cmd_req_valid), 64'(1));
      chk("t4_op", 64'(cmd_req_op), 64'(12'h3C5));
      chk("t4_op_mod", 64'(cmd_req_op_mod), 64'(8'h7E));
      chk("t4_in_param", cmd_req_in_param, 64'hA5A5_0000_1111_2222);
      chk("t4_in_mod", 64'(cmd_req_in_mod), 64'(32'hDEAD_BEEF));
      chk("t4_out_addr", cmd_req_out_addr, 64'h0000_0001_0000_0040);
      if (i == 4) pio_hcr_go = 0;
      if (i == 6) pio_hcr_go = 1;
      tick();
    end
    cmd_req_ready = 1; tick();
    chk("t4_req_taken", 64'(cmd_req_valid), 64'(0));
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h01; cmd_rsp_out_param = 64'h10; tick();
    cmd_rsp_valid = 0;
    chk("t4_clear", 64'(pio_hcr_clear), 64'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_restart", 64'(cmd_req_valid), 64'(0));
      chk("t4_stay_idle", 64'(hcr_busy), 64'(0));
      tick();
    end

    // Reset in WAIT with go held high
    pio_hcr_go = 0; tick();
    set_cmd(12'h022, 8'h00, 64'h0, 32'h0, 64'h0, 16'h0, 1'b1);
    pio_hcr_go = 1; tick();
    tick();
    chk("t5_in_wait", 64'(cmd_rsp_ready), 64'(1));
    rst = 1;
    #1;
    chk("t5_busy", 64'(hcr_busy), 64'(0));
    chk("t5_req", 64'(cmd_req_valid), 64'(0));
    chk("t5_rsp_ready", 64'(cmd_rsp_ready), 64'(0));
    chk("t5_evt", 64'(eq_evt_valid), 64'(0));
    chk("t5_clear", 64'(pio_hcr_clear), 64'(0));
    chk("t5_status", 64'(pio_hcr_status), 64'(0));
    chk("t5_out", pio_hcr_out_param, 64'h0);
    chk("t5_op", 64'(cmd_req_op), 64'(0));
    tick();
    rst = 0;
    #1 chk("t5_rel_ready", 64'(cmd_rsp_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_held_go", 64'(cmd_req_valid), 64'(0));
    end
    pio_hcr_go = 0; tick();
    pio_hcr_go = 1; tick();
    chk("t5_rego", 64'(cmd_req_valid), 64'(1));
    tick();
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h02; tick();
    cmd_rsp_valid = 0; eq_evt_ready = 1; tick();
    eq_evt_ready = 0; tick(); tick();

    // Response on the exact timeout cycle wins
    pio_hcr_go = 0; tick();
    set_cmd(12'h033, 8'h00, 64'h0, 32'h0, 64'h0, 16'h0, 1'b0);
    pio_hcr_go = 1; tick();
    repeat (15) tick();
    cmd_rsp_valid = 1; cmd_rsp_status = 8'h5A; cmd_rsp_out_param = 64'hCAFE; tick();
    cmd_rsp_valid = 0;
    chk("t6_status", 64'(pio_hcr_status), 64'(8'h5A));
    chk("t6_out", pio_hcr_out_param, 64'hCAFE);
    chk("t6_clear", 64'(pio_hcr_clear), 64'(1));
    tick();

    // Randomized traffic, alternating fluid and stalled engine behaviour
    for (int i = 0; i < 4000; i++) begin
      bit stall;
      stall = ((i / 200) % 2) == 1;
      if ($urandom_range(0, 7) == 0) pio_hcr_go = ~pio_hcr_go;
      cmd_req_ready = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      cmd_rsp_valid = stall ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      cmd_rsp_status = 8'($urandom);
      cmd_rsp_out_param = {$urandom, $urandom};
      eq_evt_ready = ($urandom_range(0, 2) == 0);
      set_cmd(12'($urandom), 8'($urandom), {$urandom, $urandom}, $urandom,
              {$urandom, $urandom}, 16'($urandom), 1'($urandom));
      if (rst) rst = 0;
      else if ($urandom_range(0, 499) == 0) rst = 1;
      tick();
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
